multu_hilo: RTL



---
 rtl/alu_pkg.sv | 23 ++
 rtl/multu_step.sv | 25 ++
 rtl/multu_hilo.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath: function codes decoded by ALU
// control, the default datapath width, and the multiplier state encoding.
package alu_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  // 6-bit function codes presented by ALU control.
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/multu_step.sv
// One iteration of the unsigned shift-add multiply.
//   product_i : current {upper accumulator, remaining multiplier bits}
//   mcand_i   : latched multiplicand
//   product_o : product after add-if-LSB and logical shift right by one
module multu_step
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [2*WIDTH-1:0] product_i,
  input  logic [WIDTH-1:0]   mcand_i,
  output logic [2*WIDTH-1:0] product_o
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  always_comb begin
    addend    = product_i[0] ? mcand_i : '0;
    // Carry out of the add becomes the new MSB after the shift.
    sum       = {1'b0, product_i[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    product_o = {sum, product_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/multu_hilo.sv
// Iterative unsigned multiplier with HI/LO result registers.
//   clk, rst_n : clock, asynchronous active-low reset
//   Signal     : function code; a new MULTU code starts a multiply,
//                MFHI/MFLO select HI/LO onto dataOut
//   dataA/B    : multiplicand / multiplier, latched at start
//   dataOut    : HI on MFHI, LO on MFLO, otherwise zero
//   busy       : high while iterating
//   done       : one-cycle pulse after HI/LO are written
module multu_hilo
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] prod_step;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         prev_sig_q;
  logic               done_q, done_d;
  logic               start;

  multu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .product_i(prod_q),
    .mcand_i  (mcand_q),
    .product_o(prod_step)
  );

  // Edge detect on the code so a held MULTU launches only one multiply.
  assign start = (Signal == FN_MULTU) && (prev_sig_q != FN_MULTU);

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = dataA;
          prod_d  = {{WIDTH{1'b0}}, dataB};
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          hi_d    = prod_step[2*WIDTH-1:WIDTH];
          lo_d    = prod_step[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      mcand_q    <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      prev_sig_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      mcand_q    <= mcand_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
      prev_sig_q <= Signal;
      done_q     <= done_d;
    end
  end

  always_comb begin
    case (Signal)
      FN_MFHI: dataOut = hi_q;
      FN_MFLO: dataOut = lo_q;
      default: dataOut = '0;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule
